btb_update_queue: RTL
=====================

# btb_update_queue

Decoupling queue between branch resolution in execute and the BTB update port. It accepts resolved control-flow instructions over a valid/ready handshake and filters out correctly predicted ones. Remaining entries are buffered in a small FIFO and drained one per cycle onto the BTB's single write port (`update_*`), so execute never stalls on a BTB write and only mispredicted-target branches consume write bandwidth.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2.
- `CNT_W`, $clog2(DEPTH)+1, width of `count_o`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `resolve_valid_i`  in  1  resolved instruction presented.
- `resolve_ready_o`  out  1  queue can accept this cycle.
- `resolve_pc_i`  in  32  instruction PC.
- `resolve_target_i`  in  32  actual target.
- `resolve_taken_i`  in  1  branch actually taken.
- `resolve_is_branch_i`  in  1  instruction is control flow.
- `resolve_is_call_i`  in  1  call.
- `resolve_is_return_i`  in  1  return.
- `resolve_pred_hit_i`  in  1  fetch-time BTB hit.
- `resolve_pred_target_i`  in  32  fetch-time predicted target.
- `flush_i`  in  1  discard all queued entries.
- `drain_stall_i`  in  1  hold the BTB write port this cycle.
- `update_valid_o`  out  1  BTB write strobe.
- `update_pc_o`  out  32  write PC.
- `update_target_o`  out  32  write target.
- `update_is_branch_o`  out  1  always 1 when `update_valid_o`.
- `update_is_call_o`  out  1  call flag.
- `update_is_return_o`  out  1  return flag.
- `count_o`  out  CNT_W  occupied entries.

## Operation
- Handshake: a transfer occurs when `resolve_valid_i && resolve_ready_o`. `resolve_ready_o = (count < DEPTH)`, registered-count based with no same-cycle pop pass-through.
- Filter: an accepted instruction is enqueued only if `is_branch && taken && !(pred_hit && pred_target == target)`. Otherwise it is consumed and discarded.
- Storage: circular FIFO with write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. Each entry holds pc, target, is_call and is_return.
- Drain: `update_valid_o = (count != 0) && !drain_stall_i && !flush_i`. `update_*` are driven combinationally from the head entry. The head pops in any cycle where `update_valid_o` is 1.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- `flush_i`:
  - Next edge: count=0 and pointers=0.
  - In the flush cycle, any accepted input is dropped and no write is issued.
  - `resolve_ready_o` follows normal count rules.
- `update_is_branch_o` equals `update_valid_o`.
- Outputs are all 0 whenever `update_valid_o` is 0.

## Timing
- Reset, asynchronous: count=0 and pointers=0. Consequently `resolve_ready_o`=1, `update_valid_o`=0, all `update_*`=0 and `count_o`=0. Entry contents need no reset.
- Latency: an entry accepted at edge N is presented on `update_*` in the cycle after edge N, at the earliest. There is no bypass.
- Throughput: one accept and one BTB write per cycle sustained.
- Full (count=DEPTH): `resolve_ready_o`=0 even if a pop occurs this cycle.
- Empty: `update_valid_o`=0 regardless of input.
- `drain_stall_i` holds the head entry and its outputs stable. Filling continues while stalled.
- Reset asserted mid-operation: all entries are lost immediately.

## Configuration
- `BTB_UPDQ_COALESCE_EN` defined:
  - An enqueue-eligible input whose PC equals a queued, non-popping entry's PC overwrites that entry's target/call/return in place and does not allocate.
  - A coalesce is accepted even when full, so `resolve_ready_o` becomes `count<DEPTH || pc matches a non-popping entry`.
  - If the only match is the head popping this cycle, a new entry is allocated instead (needs count<DEPTH).
  - If several entries match, the youngest is updated.
- Undefined: no PC compare. Every eligible input allocates, so duplicates are written in order.

## Test plan
- Reset, then accept taken branch pc=0x1000, target=0x2000, pred_hit=0 -> `update_valid_o`=1 next cycle with pc 0x1000 and target 0x2000; `count_o` returns to 0.
- Correct prediction (pred_hit=1, pred_target=0x2000=target) and not-taken branch -> both accepted, `update_valid_o` stays 0, `count_o` stays 0.
- With `drain_stall_i`=1, push 8 eligible branches (DEPTH=8) -> `count_o`=8 and `resolve_ready_o`=0. Release the stall -> 8 writes on consecutive cycles in push order, then ready=1.
- Push and pop in the same cycle at count=3 -> count stays 3. Push 20 entries with continuous drain -> pointer wraparound; outputs match push order.
- Assert `flush_i` with count=5 and a valid input -> no write that cycle, `count_o`=0 next cycle, flushed input is never written.
- Coalesce, with the macro defined and stall held: push pc=0x40 tgt=0x100, then pc=0x40 tgt=0x200 -> count=1, single write with tgt 0x200. Without the macro -> count=2, writes 0x100 then 0x200.

Source files
------------

// File: rtl/btb_update_queue.sv
// Decoupling FIFO between branch resolution and the BTB write port; correctly
// predicted or non-taken instructions are dropped. Define BTB_UPDQ_COALESCE_EN to merge same-PC entries.
module btb_update_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             resolve_valid_i,
  output logic             resolve_ready_o,
  input  logic [31:0]      resolve_pc_i,
  input  logic [31:0]      resolve_target_i,
  input  logic             resolve_taken_i,
  input  logic             resolve_is_branch_i,
  input  logic             resolve_is_call_i,
  input  logic             resolve_is_return_i,
  input  logic             resolve_pred_hit_i,
  input  logic [31:0]      resolve_pred_target_i,
  input  logic             flush_i,
  input  logic             drain_stall_i,
  output logic             update_valid_o,
  output logic [31:0]      update_pc_o,
  output logic [31:0]      update_target_o,
  output logic             update_is_branch_o,
  output logic             update_is_call_o,
  output logic             update_is_return_o,
  output logic [CNT_W-1:0] count_o
);
  // Handshake: a resolved instruction transfers on any cycle where
  // resolve_valid_i && resolve_ready_o; update_* is a pure strobe with no back-pressure.
  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      pc_mem  [DEPTH];
  logic [31:0]      tgt_mem [DEPTH];
  logic             call_mem[DEPTH];
  logic             ret_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic             eligible, not_full, pop, accept, do_write, alloc, coalesce;
  logic             match_hit;
  logic [PTR_W-1:0] match_idx;

  assign eligible = resolve_is_branch_i && resolve_taken_i &&
                    !(resolve_pred_hit_i && (resolve_pred_target_i == resolve_target_i));
  assign not_full = (count < CNT_W'(DEPTH));
  assign pop      = (count != '0) && !drain_stall_i && !flush_i;

`ifdef BTB_UPDQ_COALESCE_EN
  logic [PTR_W-1:0] slot;

  // Walk from head to tail so the last hit is the youngest matching entry;
  // the head is excluded when it leaves this cycle.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    slot      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && !((k == 0) && pop) &&
          (pc_mem[slot] == resolve_pc_i)) begin
        match_hit = 1'b1;
        match_idx = slot;
      end
    end
  end
`else
  assign match_hit = 1'b0;
  assign match_idx = '0;
`endif

  assign resolve_ready_o = not_full || match_hit;
  assign accept          = resolve_valid_i && resolve_ready_o;
  assign do_write        = accept && eligible && !flush_i;
  assign coalesce        = do_write && match_hit;
  assign alloc           = do_write && !match_hit;

  // Entry payload carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_mem[wr_ptr]   <= resolve_pc_i;
      tgt_mem[wr_ptr]  <= resolve_target_i;
      call_mem[wr_ptr] <= resolve_is_call_i;
      ret_mem[wr_ptr]  <= resolve_is_return_i;
    end else if (coalesce) begin
      tgt_mem[match_idx]  <= resolve_target_i;
      call_mem[match_idx] <= resolve_is_call_i;
      ret_mem[match_idx]  <= resolve_is_return_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (alloc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({alloc, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign update_valid_o     = pop;
  assign update_is_branch_o = pop;
  assign update_pc_o        = pop ? pc_mem[rd_ptr]   : 32'h0;
  assign update_target_o    = pop ? tgt_mem[rd_ptr]  : 32'h0;
  assign update_is_call_o   = pop ? call_mem[rd_ptr] : 1'b0;
  assign update_is_return_o = pop ? ret_mem[rd_ptr]  : 1'b0;
  assign count_o            = count;
endmodule
